sev_seg_scanner: RTL and testbench
==================================

// Module: sev_seg_scanner
// PURPOSE
//  Downstream of the RTC time counter. Takes six 7-segment patterns (HH:MM:SS) and drives one shared
//  segment bus plus six digit enables as a time-multiplexed display.
//  - Snapshots the patterns only at frame boundaries, so a digit never changes mid-frame (no tearing).
//  - Inserts a blanking gap between digits to suppress ghosting.
// PARAMETERS
//  CLK_DIV      25000  clk cycles per scan tick (>=1)
//  ON_TICKS     2      ticks each digit is lit (>=1)
//  BLANK_TICKS  1      ticks of blanking after each digit (0 = no blanking state)
//  ACTIVE_LOW   1      1: segment/digit "on" = 0, "off" = 1; 0: inverse
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-low
//  seg_in     in   42  digit k pattern at [7k+6:7k], {g,f,e,d,c,b,a}, 1 = segment lit; k=0..5
//  frame_upd  in   1   1-cycle pulse: seg_in holds new valid data
//  dig_sel    out  6   digit enables, one-hot when lit (polarity per ACTIVE_LOW)
//  seg_out    out  7   shared segment bus (polarity per ACTIVE_LOW)
//  frame_done out  1   1-cycle pulse when a full 6-digit frame has completed
//  duty       in   4   brightness; present only with SCAN_DIM_EN
// BEHAVIOUR
//  - OFF = all-ones if ACTIVE_LOW=1, else all-zeros. All outputs are registered and update on the
//    same edge as the state.
//  - Reset (async, rst=0):
//    - outputs: dig_sel=OFF, seg_out=OFF, frame_done=0
//    - internal: state=LOAD, digit index idx=0, prescaler=0, pending=1, shadow regs=0
//  - FSM states: LOAD, ON, BLANK.
//    - LOAD: lasts exactly 1 cycle.
//      - If (pending | frame_upd): shadow <= seg_in and pending <= 0.
//      - idx <= 0; next state ON.
//    - ON: lasts ON_TICKS*CLK_DIV cycles.
//      - dig_sel: only bit idx active.
//      - seg_out = shadow[idx], polarity-mapped.
//    - BLANK: lasts BLANK_TICKS*CLK_DIV cycles; dig_sel=OFF, seg_out=OFF.
//    - After ON: go to BLANK, or skip it if BLANK_TICKS=0.
//    - After BLANK (or skipped BLANK): if idx<5 then idx+1 and next state ON; if idx==5 then LOAD.
//  - Prescaler: counts 0..CLK_DIV-1 and clears on every state entry. Tick = (prescaler==CLK_DIV-1).
//    A tick counter clears on state entry and counts ticks.
//  - Frame period: 1 + 6*(ON_TICKS+BLANK_TICKS)*CLK_DIV cycles.
//  - frame_done: =1 in the LOAD cycle entered from idx==5. Not asserted in the LOAD cycle after reset.
//  - frame_upd: sets pending in any non-LOAD cycle. Repeated pulses within a frame collapse into one;
//    the data captured is seg_in as presented in the LOAD cycle.
//    - frame_upd in the LOAD cycle itself is honoured immediately.
//  - seg_in is ignored outside LOAD. The caller must hold it stable from its frame_upd pulse until
//    the next frame_done.
//  - Reset mid-frame: outputs go OFF immediately (async); scanning restarts at LOAD with idx=0.
// CONFIGURATION
//  - SCAN_DIM_EN defined:
//    - duty port exists.
//    - A free-running 4-bit counter ph increments every clk, reset 0.
//    - In ON, seg_out shows the pattern only when ph<=duty, else OFF.
//    - dig_sel is unaffected.
//    - duty=15: always lit. duty=0: lit 1 of 16 cycles.
//  - SCAN_DIM_EN undefined: no duty port, no ph counter; full brightness throughout ON.
// TESTING  (CLK_DIV=4, ON_TICKS=2, BLANK_TICKS=1, ACTIVE_LOW=1; frame = 73 cycles)
//  1. Reset release, seg_in=digits 1..6 ({k+1} patterns), no frame_upd
//     -> cycle 0 LOAD, no frame_done.
//     -> dig_sel=6'b111110 for 8 cycles with seg_out=~pattern(1).
//     -> then 4 cycles of all-ones.
//     -> then dig_sel=6'b111101.
//  2. Free run -> frame_done pulses exactly every 73 cycles, 1 cycle wide.
//     -> never 2+ bits of dig_sel low at once.
//     -> seg_out=7'h7F whenever dig_sel==6'h3F.
//  3. Change seg_in digit 0 to 0x3F plus frame_upd mid-frame (during idx=2)
//     -> current frame keeps the old patterns.
//     -> new pattern appears on the next idx=0 ON only.
//  4. Change seg_in without frame_upd -> outputs never change.
//     Then frame_upd pulsed in the LOAD cycle -> captured that same frame.
//  5. Assert rst during idx=3 ON -> dig_sel=6'h3F, seg_out=7'h7F in the same cycle.
//     On release, digit 0 is lit again after 1 cycle.
//  6. SCAN_DIM_EN, duty=3 -> per 16 cycles within ON, seg_out active for exactly 4 cycles
//     while dig_sel stays low. Without SCAN_DIM_EN the same bench sees 8/8 lit.

Source files
------------

// File: rtl/sev_seg_scanner.sv
// Six-digit multiplexed 7-segment scanner. Patterns are snapshotted at frame boundaries and
// each digit is followed by a blanking gap. Define SCAN_DIM_EN to add the duty dimming input.
module sev_seg_scanner #(
    parameter int unsigned CLK_DIV     = 25000,
    parameter int unsigned ON_TICKS    = 2,
    parameter int unsigned BLANK_TICKS = 1,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [41:0] seg_in,
    input  logic        frame_upd,
`ifdef SCAN_DIM_EN
    input  logic [3:0]  duty,
`endif
    output logic [5:0]  dig_sel,
    output logic [6:0]  seg_out,
    output logic        frame_done
);

    localparam int unsigned PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned MAX_TICKS = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic          POL        = (ACTIVE_LOW != 0);
    localparam logic [5:0]    OFF_DIG    = {6{POL}};
    localparam logic [6:0]    OFF_SEG    = {7{POL}};

    typedef enum logic [1:0] {StLoad, StOn, StBlank} state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            pending_q, pending_d;
    logic [41:0]     shadow_q, shadow_d;
    logic [5:0]      dig_sel_d;
    logic [6:0]      seg_out_d;
    logic            frame_done_d;
    logic            tick, advance, next_digit, lit;
    logic [6:0]      digit_raw;
`ifdef SCAN_DIM_EN
    logic [3:0]      ph_q, ph_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StLoad;
            idx_q      <= '0;
            presc_q    <= '0;
            tcnt_q     <= '0;
            pending_q  <= 1'b1;
            shadow_q   <= '0;
            dig_sel    <= OFF_DIG;
            seg_out    <= OFF_SEG;
            frame_done <= 1'b0;
`ifdef SCAN_DIM_EN
            ph_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            presc_q    <= presc_d;
            tcnt_q     <= tcnt_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            dig_sel    <= dig_sel_d;
            seg_out    <= seg_out_d;
            frame_done <= frame_done_d;
`ifdef SCAN_DIM_EN
            ph_q       <= ph_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        presc_d    = presc_q + PW'(1);
        tcnt_d     = tcnt_q;
        pending_d  = pending_q | frame_upd;
        shadow_d   = shadow_q;
        advance    = 1'b0;
        next_digit = 1'b0;
        tick       = (presc_q == PRESC_LAST);

        unique case (state_q)
            StLoad: begin
                // A pulse in this very cycle is honoured along with any earlier pending one.
                if (pending_q || frame_upd) shadow_d = seg_in;
                pending_d = 1'b0;
                idx_d     = '0;
                state_d   = StOn;
                advance   = 1'b1;
            end
            StOn: begin
                if (tick && tcnt_q == ON_LAST) begin
                    advance = 1'b1;
                    if (BLANK_TICKS != 0) state_d = StBlank;
                    else next_digit = 1'b1;
                end
            end
            StBlank: begin
                if (tick && tcnt_q == BLANK_LAST) begin
                    advance    = 1'b1;
                    next_digit = 1'b1;
                end
            end
            default: begin
                state_d = StLoad;
                advance = 1'b1;
            end
        endcase

        if (next_digit) begin
            if (idx_q == 3'd5) begin
                state_d = StLoad;
            end else begin
                idx_d   = idx_q + 3'd1;
                state_d = StOn;
            end
        end

        // Both counters restart on every state entry, including ON->ON with no blanking.
        if (advance) begin
            presc_d = '0;
            tcnt_d  = '0;
        end else if (tick) begin
            presc_d = '0;
            tcnt_d  = tcnt_q + TW'(1);
        end

        frame_done_d = next_digit && (idx_q == 3'd5);
        digit_raw    = shadow_d[{3'd0, idx_d} * 6'd7 +: 7];
        lit          = 1'b1;
`ifdef SCAN_DIM_EN
        ph_d = ph_q + 4'd1;
        lit  = (ph_d <= duty);
`endif
        dig_sel_d = OFF_DIG;
        seg_out_d = OFF_SEG;
        if (state_d == StOn) begin
            dig_sel_d = (6'd1 << idx_d) ^ OFF_DIG;
            if (lit) seg_out_d = digit_raw ^ OFF_SEG;
        end
    end

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Randomized bench for sev_seg_scanner; a cycle-position model of the frame predicts every
// output cycle by cycle.
module tb_sev_seg_scanner;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned ON_TICKS    = 2;
    localparam int unsigned BLANK_TICKS = 1;
    localparam int          SLOT        = (ON_TICKS + BLANK_TICKS) * CLK_DIV;
    localparam int          ON_CYC      = ON_TICKS * CLK_DIV;
    localparam int          FRAME       = 1 + 6 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [41:0] seg_in = '0;
    logic        frame_upd = 1'b0;
    logic [5:0]  dig_sel;
    logic [6:0]  seg_out;
    logic        frame_done;
`ifdef SCAN_DIM_EN
    logic [3:0]  duty = 4'd3;
    logic [3:0]  duty_prev;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          c;
    logic        pend;
    logic [41:0] sh;
    logic [41:0] cur;

    sev_seg_scanner #(
        .CLK_DIV     (CLK_DIV),
        .ON_TICKS    (ON_TICKS),
        .BLANK_TICKS (BLANK_TICKS),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .frame_upd  (frame_upd),
`ifdef SCAN_DIM_EN
        .duty       (duty),
`endif
        .dig_sel    (dig_sel),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    // Called at the negedge inside cycle c: check outputs, drive this cycle's inputs.
    task automatic step(input string tag, input logic [41:0] si, input logic fu);
        int p;
        int q;
        int d;
        logic [5:0] e_dig;
        logic [6:0] e_seg;
        logic       e_fd;
        p     = c % FRAME;
        e_dig = 6'h3F;
        e_seg = 7'h7F;
        e_fd  = 1'b0;
        if (p == 0) begin
            e_fd = (c != 0);
        end else begin
            q = p - 1;
            d = q / SLOT;
            if ((q % SLOT) < ON_CYC) begin
                e_dig = ~(6'd1 << d);
                e_seg = ~sh[d*7 +: 7];
`ifdef SCAN_DIM_EN
                if ((c % 16) > int'(duty_prev)) e_seg = 7'h7F;
`endif
            end
        end
        check(tag, {18'd0, dig_sel, seg_out, frame_done}, {18'd0, e_dig, e_seg, e_fd});
        seg_in    = si;
        frame_upd = fu;
        if (p == 0) begin
            if (pend || fu) sh = si;
            pend = 1'b0;
        end else if (fu) begin
            pend = 1'b1;
        end
`ifdef SCAN_DIM_EN
        duty_prev = duty;
`endif
        @(negedge clk);
        c++;
    endtask

    task automatic model_reset();
        c    = 0;
        pend = 1'b1;
        sh   = '0;
`ifdef SCAN_DIM_EN
        duty_prev = duty;
`endif
    endtask

    initial begin
        logic [41:0] pat;
        logic [41:0] pat2;
        logic        fu;
        // Digits 1..6 on positions 0..5.
        pat  = {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
        pat2 = {pat[41:7], 7'h3F};
        c    = 0;
        pend = 1'b1;
        sh   = '0;
        seg_in = pat;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();

        for (int i = 0; i < 2 * FRAME; i++) step("free_run", pat, 1'b0);

        // Update requested while digit 2 is lit: current frame must stay old.
        for (int i = 0; i < 2 * FRAME; i++) step("upd_mid", (i >= 30) ? pat2 : pat, i == 30);

        // Data churn with no update request must be invisible.
        for (int i = 0; i < FRAME; i++) step("no_upd", 42'({$urandom(), $urandom()}), 1'b0);

        // Update pulse exactly in the LOAD cycle is captured immediately.
        cur = 42'({$urandom(), $urandom()});
        for (int i = 0; i < FRAME + 1; i++) step("upd_load", cur, i == 0);

        for (int i = 0; i < 15 * FRAME; i++) begin
            if ($urandom_range(3) == 0) cur = 42'({$urandom(), $urandom()});
            if ((c % FRAME) == 0) begin
                fu = 1'($urandom_range(1));
`ifdef SCAN_DIM_EN
                duty = 4'($urandom_range(15));
`endif
            end else begin
                fu = ($urandom_range(39) == 0);
            end
            step("rand", cur, fu);
        end

`ifdef SCAN_DIM_EN
        duty = 4'd3;
`endif
        // Run into digit 3's lit window, then reset asynchronously.
        for (int i = 0; i < FRAME && (c % FRAME) != 1 + 3 * SLOT + 2; i++) step("pre_rst", cur, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("async_rst", {18'd0, dig_sel, seg_out, frame_done}, {18'd0, 6'h3F, 7'h7F, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) step("post_rst", cur, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
